ess_decel_detector: RTL and testbench

//   Emergency Stop Signal (ESS) trigger generator. Samples vehicle speed once per

---
 rtl/ess_decel_detector_if.sv | 24 ++
 rtl/ess_decel_detector.sv | 114 +++++++++++
 tb/tb_ess_decel_detector.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/ess_decel_detector_if.sv
// Pedal/speed inputs and ESS status outputs of the deceleration detector.
// The master drives vehicle inputs; the slave (detector) drives status.
interface ess_decel_detector_if #(
    parameter int SPEED_W = 8
);
    logic               tick_1sec;
    logic [SPEED_W-1:0] speed;
    logic               brake_pressed;
    logic               is_accel_pressed;
    logic               ess_trigger;
    logic [SPEED_W-1:0] decel_out;
    logic               armed;
    logic               fired;

    modport master (
        output tick_1sec, speed, brake_pressed, is_accel_pressed,
        input  ess_trigger, decel_out, armed, fired
    );

    modport slave (
        input  tick_1sec, speed, brake_pressed, is_accel_pressed,
        output ess_trigger, decel_out, armed, fired
    );
endinterface

// File: rtl/ess_decel_detector.sv
// Emergency Stop Signal trigger: samples speed once per second while braking and
// pulses ess_trigger after CONFIRM_CNT consecutive hard-deceleration samples.
module ess_decel_detector #(
    parameter int SPEED_W      = 8,
    parameter int DECEL_THRESH = 20,
    parameter int MIN_SPEED    = 40,
    parameter int CONFIRM_CNT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ess_decel_detector_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_FIRED = 2'd2;

    localparam logic [SPEED_W-1:0] THRESH_V  = SPEED_W'(DECEL_THRESH);
    localparam logic [SPEED_W-1:0] MIN_V     = SPEED_W'(MIN_SPEED);
    localparam logic [2:0]         CONFIRM_V = 3'(CONFIRM_CNT);

    logic [1:0]         state, state_nxt;
    logic [SPEED_W-1:0] prev_speed, prev_nxt;
    logic [SPEED_W-1:0] decel_nxt;
    logic [2:0]         hit_cnt, hit_nxt;
    logic               trig_nxt;

    logic [SPEED_W-1:0] decel;
    logic               is_hit;
    logic               exit_req;
    logic               start_ok;
    logic [2:0]         hit_inc;

    // Subtract only when speed fell, so a rising speed reads as zero drop.
    assign decel    = (prev_speed > bus.speed) ? prev_speed - bus.speed : '0;
    assign is_hit   = (decel >= THRESH_V) && (prev_speed >= MIN_V);
    assign exit_req = !bus.brake_pressed || bus.is_accel_pressed;
    assign start_ok = bus.brake_pressed && !bus.is_accel_pressed && (bus.speed >= MIN_V);
    assign hit_inc  = hit_cnt + 3'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nxt = state;
        prev_nxt  = prev_speed;
        hit_nxt   = hit_cnt;
        decel_nxt = bus.decel_out;
        trig_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.tick_1sec && start_ok) begin
                    prev_nxt  = bus.speed;
                    hit_nxt   = 3'd0;
                    state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Pedal exit outranks a coincident tick: no measurement, no pulse.
                if (exit_req) begin
                    hit_nxt   = 3'd0;
                    state_nxt = ST_IDLE;
                end else if (bus.tick_1sec) begin
                    decel_nxt = decel;
                    prev_nxt  = bus.speed;
                    if (is_hit) begin
                        hit_nxt = hit_inc;
                        if (hit_inc == CONFIRM_V) begin
                            trig_nxt  = 1'b1;
                            state_nxt = ST_FIRED;
                        end
                    end else begin
                        hit_nxt = 3'd0;
                    end
                end
            end
            ST_FIRED: begin
                if (exit_req) begin
                    hit_nxt   = 3'd0;
                    state_nxt = ST_IDLE;
                end else if (bus.tick_1sec) begin
                    decel_nxt = decel;
                    prev_nxt  = bus.speed;
                end
            end
            default: begin
                hit_nxt   = 3'd0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // armed/fired are registered copies of the next state so they move on the
    // same edge as the state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state           <= ST_IDLE;
            prev_speed      <= '0;
            hit_cnt         <= 3'd0;
            bus.decel_out   <= '0;
            bus.ess_trigger <= 1'b0;
            bus.armed       <= 1'b0;
            bus.fired       <= 1'b0;
        end else begin
            state           <= state_nxt;
            prev_speed      <= prev_nxt;
            hit_cnt         <= hit_nxt;
            bus.decel_out   <= decel_nxt;
            bus.ess_trigger <= trig_nxt;
            bus.armed       <= (state_nxt == ST_ARMED);
            bus.fired       <= (state_nxt == ST_FIRED);
        end
    end

endmodule

// File: tb/tb_ess_decel_detector.sv
// Table-driven bench for ess_decel_detector: one DUT with CONFIRM_CNT=1, one with
// CONFIRM_CNT=2, sharing stimulus; expected outputs flow through a scoreboard queue.
module tb_ess_decel_detector;

    logic clk = 1'b0;
    logic rst;

    always #10 clk = ~clk;

    ess_decel_detector_if #(.SPEED_W(8)) bus1 ();
    ess_decel_detector_if #(.SPEED_W(8)) bus2 ();

    assign bus2.tick_1sec        = bus1.tick_1sec;
    assign bus2.speed            = bus1.speed;
    assign bus2.brake_pressed    = bus1.brake_pressed;
    assign bus2.is_accel_pressed = bus1.is_accel_pressed;

    ess_decel_detector #(.SPEED_W(8), .DECEL_THRESH(20), .MIN_SPEED(40), .CONFIRM_CNT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    ess_decel_detector #(.SPEED_W(8), .DECEL_THRESH(20), .MIN_SPEED(40), .CONFIRM_CNT(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    typedef struct {
        logic       sel;
        logic       rst;
        logic       tick;
        logic [7:0] speed;
        logic       brake;
        logic       accel;
        logic       exp_trig;
        logic [7:0] exp_decel;
        logic       exp_armed;
        logic       exp_fired;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb[$];
    vec_t tbl[$];
    vec_t seq2[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic sel, input logic r, input logic tk, input int spd,
                               input logic brk, input logic acc, input logic trg,
                               input int dcl, input logic arm, input logic fir);
        vec_t x;
        x.sel = sel; x.rst = r; x.tick = tk; x.speed = 8'(spd);
        x.brake = brk; x.accel = acc; x.exp_trig = trg; x.exp_decel = 8'(dcl);
        x.exp_armed = arm; x.exp_fired = fir;
        return x;
    endfunction

    task automatic step(input vec_t x, input int idx);
        vec_t e;
        @(negedge clk);
        rst                   = x.rst;
        bus1.tick_1sec        = x.tick;
        bus1.speed            = x.speed;
        bus1.brake_pressed    = x.brake;
        bus1.is_accel_pressed = x.accel;
        sb.push_back(x);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.sel) begin
            check($sformatf("cc2[%0d].trig",  idx), int'(bus2.ess_trigger), int'(e.exp_trig));
            check($sformatf("cc2[%0d].decel", idx), int'(bus2.decel_out),   int'(e.exp_decel));
            check($sformatf("cc2[%0d].armed", idx), int'(bus2.armed),       int'(e.exp_armed));
            check($sformatf("cc2[%0d].fired", idx), int'(bus2.fired),       int'(e.exp_fired));
        end else begin
            check($sformatf("cc1[%0d].trig",  idx), int'(bus1.ess_trigger), int'(e.exp_trig));
            check($sformatf("cc1[%0d].decel", idx), int'(bus1.decel_out),   int'(e.exp_decel));
            check($sformatf("cc1[%0d].armed", idx), int'(bus1.armed),       int'(e.exp_armed));
            check($sformatf("cc1[%0d].fired", idx), int'(bus1.fired),       int'(e.exp_fired));
        end
    endtask

    initial begin
        rst                   = 1'b1;
        bus1.tick_1sec        = 1'b0;
        bus1.speed            = 8'd0;
        bus1.brake_pressed    = 1'b0;
        bus1.is_accel_pressed = 1'b0;

        //                  sel r  tk spd brk acc  trg dcl arm fir
        // Reset state
        tbl.push_back(v(0, 1, 0,   0, 0, 0,  0,  0, 0, 0));
        tbl.push_back(v(0, 1, 0,   0, 0, 0,  0,  0, 0, 0));
        // 100 -> 75 fires one-clock pulse
        tbl.push_back(v(0, 0, 1, 100, 1, 0,  0,  0, 1, 0));
        tbl.push_back(v(0, 0, 0, 100, 1, 0,  0,  0, 1, 0));
        tbl.push_back(v(0, 0, 1,  75, 1, 0,  1, 25, 0, 1));
        tbl.push_back(v(0, 0, 0,  75, 1, 0,  0, 25, 0, 1));
        // Lockout: 75 -> 50 measured, no second pulse; release; re-arm 60 -> 35 fires
        tbl.push_back(v(0, 0, 1,  50, 1, 0,  0, 25, 0, 1));
        tbl.push_back(v(0, 0, 0,  50, 0, 0,  0, 25, 0, 0));
        tbl.push_back(v(0, 0, 1,  60, 1, 0,  0, 25, 1, 0));
        tbl.push_back(v(0, 0, 1,  35, 1, 0,  1, 25, 0, 1));
        tbl.push_back(v(0, 0, 0,  35, 0, 0,  0, 25, 0, 0));
        // 100 -> 85 is a weak drop
        tbl.push_back(v(0, 0, 1, 100, 1, 0,  0, 25, 1, 0));
        tbl.push_back(v(0, 0, 1,  85, 1, 0,  0, 15, 1, 0));
        // Brake release with coincident qualifying tick: no pulse, decel held
        tbl.push_back(v(0, 0, 1,  60, 0, 0,  0, 15, 0, 0));
        // Below MIN_SPEED never arms; IDLE tick leaves decel alone
        tbl.push_back(v(0, 0, 1,  30, 1, 0,  0, 15, 0, 0));
        tbl.push_back(v(0, 0, 1,   5, 1, 0,  0, 15, 0, 0));
        // Rising speed reads zero drop
        tbl.push_back(v(0, 0, 1,  80, 1, 0,  0, 15, 1, 0));
        tbl.push_back(v(0, 0, 1,  90, 1, 0,  0,  0, 1, 0));
        // Accelerator exits ARMED and blocks arming
        tbl.push_back(v(0, 0, 0,  90, 1, 1,  0,  0, 0, 0));
        tbl.push_back(v(0, 0, 1,  45, 1, 1,  0,  0, 0, 0));
        // Stay ARMED below MIN_SPEED; drop of 20 from prev 30 is not a hit
        tbl.push_back(v(0, 0, 1,  45, 1, 0,  0,  0, 1, 0));
        tbl.push_back(v(0, 0, 1,  30, 1, 0,  0, 15, 1, 0));
        tbl.push_back(v(0, 0, 1,  10, 1, 0,  0, 20, 1, 0));
        tbl.push_back(v(0, 0, 0,  10, 0, 0,  0, 20, 0, 0));
        // Boundaries: arm at exactly 40, drop of exactly 20 fires
        tbl.push_back(v(0, 0, 1,  40, 1, 0,  0, 20, 1, 0));
        tbl.push_back(v(0, 0, 1,  20, 1, 0,  1, 20, 0, 1));
        tbl.push_back(v(0, 0, 0,  20, 0, 0,  0, 20, 0, 0));
        // Drop of 19 does not fire
        tbl.push_back(v(0, 0, 1,  59, 1, 0,  0, 20, 1, 0));
        tbl.push_back(v(0, 0, 1,  40, 1, 0,  0, 19, 1, 0));
        // Reset coincident with a qualifying tick suppresses the pulse
        tbl.push_back(v(0, 1, 1,  20, 1, 0,  0,  0, 0, 0));
        // Reset during FIRED
        tbl.push_back(v(0, 0, 1, 100, 1, 0,  0,  0, 1, 0));
        tbl.push_back(v(0, 0, 1,  70, 1, 0,  1, 30, 0, 1));
        tbl.push_back(v(0, 1, 0,  70, 1, 0,  0,  0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

        // CONFIRM_CNT=2: drops 25, 10, 25, 25 fire only on the fourth
        seq2.push_back(v(1, 1, 0,   0, 0, 0,  0,  0, 0, 0));
        seq2.push_back(v(1, 0, 1, 200, 1, 0,  0,  0, 1, 0));
        seq2.push_back(v(1, 0, 1, 175, 1, 0,  0, 25, 1, 0));
        seq2.push_back(v(1, 0, 1, 165, 1, 0,  0, 10, 1, 0));
        seq2.push_back(v(1, 0, 1, 140, 1, 0,  0, 25, 1, 0));
        seq2.push_back(v(1, 0, 0, 140, 1, 0,  0, 25, 1, 0));
        seq2.push_back(v(1, 0, 1, 115, 1, 0,  1, 25, 0, 1));
        seq2.push_back(v(1, 0, 0, 115, 1, 0,  0, 25, 0, 1));
        seq2.push_back(v(1, 0, 0, 115, 0, 0,  0, 25, 0, 0));
        // Reset mid-ARMED with one hit pending and a qualifying tick
        seq2.push_back(v(1, 0, 1, 100, 1, 0,  0, 25, 1, 0));
        seq2.push_back(v(1, 0, 1,  75, 1, 0,  0, 25, 1, 0));
        seq2.push_back(v(1, 1, 1,  50, 1, 0,  0,  0, 0, 0));
        seq2.push_back(v(1, 0, 0,  50, 1, 0,  0,  0, 0, 0));

        for (int i = 0; i < seq2.size(); i++) step(seq2[i], i);

        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
